// File: rtl/smi_sample_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : smi_sample_fifo                                               |
// | Purpose  : Buffers DATA_W-bit samples from an on-chip producer (clk      |
// |            domain) and serves them to the Pi over the SMI read port, one |
// |            word per SMI read strobe at address RD_ADDR. SMI_SOE/SMI_SA   |
// |            are asynchronous and are double-flopped before use.           |
// | Ports    : clk, rst_n (async, active low)                                |
// |            in_valid/in_data/in_ready : producer push interface           |
// |            smi_sa, smi_soe           : SMI address / read strobe (async) |
// |            smi_sd                    : SMI data lines SD17..SD0          |
// |            fill_level                : words stored (0..DEPTH)           |
// |            flag_clr                  : clears overflow/underflow         |
// |            overflow, underflow       : sticky error flags                |
// | Options  : SMI_SEQ_TAG_EN - 2-bit read sequence tag on smi_sd[17:16]    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module smi_sample_fifo #(
    parameter int                     DATA_W     = 16,
    parameter int                     DEPTH_LOG2 = 8,
    parameter int                     ADDR_W     = 6,
    parameter logic [ADDR_W-1:0]      RD_ADDR    = 6'b101010
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      in_ready,
    input  logic [ADDR_W-1:0]         smi_sa,
    input  logic                      smi_soe,
    output logic [DATA_W+1:0]         smi_sd,
    output logic [DEPTH_LOG2:0]       fill_level,
    input  logic                      flag_clr,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int unsigned               c_DEPTH    = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]       c_FULL_LVL = (DEPTH_LOG2+1)'(c_DEPTH);
    localparam logic [DEPTH_LOG2:0]       c_FILL_ONE = 1;
    localparam logic [DEPTH_LOG2-1:0]     c_PTR_ONE  = 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STROBE = 1'b1
    } state_t;

    // Storage and pointers
    logic [DATA_W-1:0]        r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0]    r_wr_ptr;
    logic [DEPTH_LOG2-1:0]    r_rd_ptr;
    logic [DEPTH_LOG2:0]      r_fill;

    // SMI input synchronizers
    logic                     r_soe_m;
    logic                     r_soe_s;
    logic [ADDR_W-1:0]        r_sa_m;
    logic [ADDR_W-1:0]        r_sa_s;

    // Read FSM
    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     w_enter;
    logic                     w_leave;
    logic                     w_hit_now;
    logic                     r_pend_pop;
    logic                     r_pend_unf;

    // Output register and flags
    logic [DATA_W-1:0]        r_sd_data;
    logic [1:0]               r_sd_tag;
    logic                     r_sd_vld;
    logic                     r_ovf;
    logic                     r_unf;

    logic                     w_empty;
    logic                     w_full;
    logic                     w_push;
    logic                     w_pop;
    logic [DATA_W-1:0]        w_head;
    logic [1:0]               w_tag;

    assign w_empty    = (r_fill == '0);
    assign w_full     = (r_fill == c_FULL_LVL);
    assign in_ready   = ~w_full;
    assign w_push     = in_valid & ~w_full;
    assign w_pop      = w_leave & r_pend_pop;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_hit_now  = (r_sa_s == RD_ADDR);

    assign smi_sd     = {r_sd_tag, r_sd_data};
    assign fill_level = r_fill;
    assign overflow   = r_ovf;
    assign underflow  = r_unf;

`ifdef SMI_SEQ_TAG_EN
    logic [1:0] r_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag <= 2'b00;
        end else if (w_pop) begin
            r_tag <= r_tag + 2'b01;
        end
    end

    assign w_tag = r_tag;
`else
    assign w_tag = 2'b00;
`endif

    // Two-flop synchronizers; the strobe idles high so it resets high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_soe_m <= 1'b1;
            r_soe_s <= 1'b1;
            r_sa_m  <= '0;
            r_sa_s  <= '0;
        end else begin
            r_soe_m <= smi_soe;
            r_soe_s <= r_soe_m;
            r_sa_m  <= smi_sa;
            r_sa_s  <= r_sa_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_enter     = 1'b0;
        w_leave     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_soe_s) begin
                    w_state_nxt = ST_STROBE;
                    w_enter     = 1'b1;
                end
            end
            ST_STROBE: begin
                if (r_soe_s) begin
                    w_state_nxt = ST_IDLE;
                    w_leave     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // The pop/underflow decision is taken from what was actually presented
    // on smi_sd when the strobe began, so a word pushed during the strobe is
    // never consumed without the Pi having seen it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_pop <= 1'b0;
            r_pend_unf <= 1'b0;
        end else if (w_enter) begin
            r_pend_pop <= w_hit_now & r_sd_vld;
            r_pend_unf <= w_hit_now & ~r_sd_vld;
        end else if (w_leave) begin
            r_pend_pop <= 1'b0;
            r_pend_unf <= 1'b0;
        end
    end

    // smi_sd tracks the head word while idle and is frozen once a strobe
    // starts. A strobe at a foreign address drives zero for its duration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sd_data <= '0;
            r_sd_tag  <= 2'b00;
            r_sd_vld  <= 1'b0;
        end else if (w_enter) begin
            if (!w_hit_now) begin
                r_sd_data <= '0;
                r_sd_tag  <= 2'b00;
                r_sd_vld  <= 1'b0;
            end
        end else if (r_state == ST_IDLE) begin
            r_sd_data <= w_empty ? '0 : w_head;
            r_sd_tag  <= w_empty ? 2'b00 : w_tag;
            r_sd_vld  <= ~w_empty;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + c_FILL_ONE;
                2'b01:   r_fill <= r_fill - c_FILL_ONE;
                default: r_fill <= r_fill;
            endcase
        end
    end

    // Sticky flags; a clear pulse takes priority over a same-cycle set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (flag_clr) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (in_valid && w_full) begin
                r_ovf <= 1'b1;
            end
            if (w_leave && r_pend_unf) begin
                r_unf <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_smi_sample_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_smi_sample_fifo                                            |
// | Purpose  : Self-checking bench for smi_sample_fifo. A queue-based model  |
// |            of the FIFO as seen by the producer and the Pi supplies the   |
// |            expected values; literal checks pin the model.                |
// | Options  : SMI_SEQ_TAG_EN - also checks the read sequence tag           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_smi_sample_fifo;

    localparam int          c_DEPTH = 256;
    localparam logic [5:0]  c_RD    = 6'b101010;
    localparam logic [5:0]  c_OTHER = 6'b000001;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [5:0]  smi_sa;
    logic        smi_soe;
    logic [17:0] smi_sd;
    logic [8:0]  fill_level;
    logic        flag_clr;
    logic        overflow;
    logic        underflow;

    smi_sample_fifo dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .smi_sa     (smi_sa),
        .smi_soe    (smi_soe),
        .smi_sd     (smi_sd),
        .fill_level (fill_level),
        .flag_clr   (flag_clr),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state
    logic [15:0] m_q[$];
    logic        m_ovf;
    logic        m_unf;
    logic [1:0]  m_tag;
    logic        chk_en;

    int n_pass;
    int n_tot;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle compare of the status outputs against the model.
    always @(posedge clk) begin
        #2;
        if (chk_en && rst_n) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, (m_q.size() < c_DEPTH)});
            chk("fill_level", {23'd0, fill_level}, m_q.size());
            chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            chk("underflow", {31'd0, underflow}, {31'd0, m_unf});
        end
    end

    task automatic push(input logic [15:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        if (m_q.size() < c_DEPTH) m_q.push_back(d);
        else                       m_ovf = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic clear_flags();
        @(negedge clk);
        flag_clr = 1'b1;
        @(posedge clk);
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge clk);
        flag_clr = 1'b0;
    endtask

    function automatic logic [1:0] model_tag();
`ifdef SMI_SEQ_TAG_EN
        return m_tag;
`else
        return 2'b00;
`endif
    endfunction

    // One complete SMI read cycle; the strobe is held long enough for the
    // synchronizers and the FSM to settle on both edges.
    task automatic smi_read(input logic [5:0] sa, output logic [17:0] sd);
        logic        hit;
        logic [17:0] exp;
        chk_en = 1'b0;
        @(negedge clk);
        smi_sa  = sa;
        smi_soe = 1'b0;
        repeat (6) @(negedge clk);
        hit = (sa == c_RD);
        exp = (hit && m_q.size() > 0) ? {model_tag(), m_q[0]} : 18'd0;
        sd  = smi_sd;
        chk("smi_sd", {14'd0, smi_sd}, {14'd0, exp});
        chk("fill_in_strobe", {23'd0, fill_level}, m_q.size());
        smi_soe = 1'b1;
        repeat (6) @(negedge clk);
        if (hit) begin
            if (m_q.size() > 0) begin
                void'(m_q.pop_front());
                m_tag = m_tag + 2'd1;
            end else begin
                m_unf = 1'b1;
            end
        end
        chk_en = 1'b1;
    endtask

    logic [17:0] sd;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass = 0; n_tot = 0;
        m_ovf = 1'b0; m_unf = 1'b0; m_tag = 2'd0; chk_en = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0;
        smi_sa = 6'd0; smi_soe = 1'b1; flag_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sd", {14'd0, smi_sd}, 32'd0);
        chk("rst_fill", {23'd0, fill_level}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_flags", {30'd0, overflow, underflow}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;

        // Three words in, three reads at the FIFO address.
        push(16'h1111); push(16'h2222); push(16'h3333);
        chk("fill3", {23'd0, fill_level}, 32'd3);
        smi_read(c_RD, sd);
        chk("rd1", {16'd0, sd[15:0]}, 32'h1111);
`ifdef SMI_SEQ_TAG_EN
        chk("tag0", {30'd0, sd[17:16]}, 32'd0);
`endif
        smi_read(c_RD, sd);
        chk("rd2", {16'd0, sd[15:0]}, 32'h2222);
`ifdef SMI_SEQ_TAG_EN
        chk("tag1", {30'd0, sd[17:16]}, 32'd1);
`endif
        smi_read(c_RD, sd);
        chk("rd3", {16'd0, sd[15:0]}, 32'h3333);
`ifdef SMI_SEQ_TAG_EN
        chk("tag2", {30'd0, sd[17:16]}, 32'd2);
`endif
        chk("fill0", {23'd0, fill_level}, 32'd0);

        // Foreign address: zero data, nothing popped.
        push(16'h4444);
        smi_read(c_OTHER, sd);
        chk("other_sd", {14'd0, sd}, 32'd0);
        chk("other_fill", {23'd0, fill_level}, 32'd1);
        smi_read(c_RD, sd);
        chk("rd4", {16'd0, sd[15:0]}, 32'h4444);
`ifdef SMI_SEQ_TAG_EN
        chk("tag3", {30'd0, sd[17:16]}, 32'd3);
`endif
        push(16'h5555);
        smi_read(c_RD, sd);
        chk("rd5", {16'd0, sd[15:0]}, 32'h5555);
`ifdef SMI_SEQ_TAG_EN
        chk("tag_wrap", {30'd0, sd[17:16]}, 32'd0);
`endif

        // Read of an empty FIFO.
        smi_read(c_RD, sd);
        chk("empty_sd", {14'd0, sd}, 32'd0);
        chk("underflow_set", {31'd0, underflow}, 32'd1);
        clear_flags();
        chk("underflow_clr", {31'd0, underflow}, 32'd0);

        // Push into an empty FIFO during a strobe: output stays frozen.
        chk_en = 1'b0;
        @(negedge clk);
        smi_sa = c_RD; smi_soe = 1'b0;
        repeat (6) @(negedge clk);
        push(16'hABCD);
        repeat (3) @(negedge clk);
        chk("frozen_sd", {14'd0, smi_sd}, 32'd0);
        smi_soe = 1'b1;
        m_unf = 1'b1;
        repeat (6) @(negedge clk);
        chk("frozen_unf", {31'd0, underflow}, 32'd1);
        chk("frozen_next", {16'd0, smi_sd[15:0]}, 32'hABCD);
        chk("frozen_fill", {23'd0, fill_level}, 32'd1);
        chk_en = 1'b1;
        smi_read(c_RD, sd);
        clear_flags();

        // Fill to DEPTH, clear-vs-set priority, then one lost word.
        for (int i = 0; i < c_DEPTH; i++) push(16'h0100 + 16'(i));
        chk("full_ready", {31'd0, in_ready}, 32'd0);
        chk("full_fill", {23'd0, fill_level}, 32'd256);
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'hBEEF; flag_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; flag_clr = 1'b0;
        chk("clr_wins", {31'd0, overflow}, 32'd0);
        push(16'hDEAD);
        chk("overflow_set", {31'd0, overflow}, 32'd1);
        chk("full_fill2", {23'd0, fill_level}, 32'd256);
        for (int i = 0; i < c_DEPTH; i++) begin
            smi_read(c_RD, sd);
            if (i == 0)           chk("drain_first", {16'd0, sd[15:0]}, 32'h0100);
            if (i == c_DEPTH - 1) chk("drain_last", {16'd0, sd[15:0]}, 32'h01FF);
        end
        chk("drain_fill", {23'd0, fill_level}, 32'd0);
        chk("drain_ready", {31'd0, in_ready}, 32'd1);
        clear_flags();

        // Reset in the middle of a strobe with data stored.
        push(16'h6666); push(16'h7777);
        chk_en = 1'b0;
        @(negedge clk);
        smi_sa = c_RD; smi_soe = 1'b0; in_valid = 1'b1; in_data = 16'h8888;
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m_q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_tag = 2'd0;
        chk("mid_rst_sd", {14'd0, smi_sd}, 32'd0);
        chk("mid_rst_fill", {23'd0, fill_level}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_flags", {30'd0, overflow, underflow}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0; smi_soe = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk_en = 1'b1;
        chk("post_rst_fill", {23'd0, fill_level}, 32'd0);
        push(16'h9999);
        smi_read(c_RD, sd);
        chk("post_rst_rd", {16'd0, sd[15:0]}, 32'h9999);
`ifdef SMI_SEQ_TAG_EN
        chk("post_rst_tag", {30'd0, sd[17:16]}, 32'd0);
`endif
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
